// File: rtl/cycle_vector_engine.sv
// Per-cycle pattern engine: plays one test vector per tester cycle onto the
// pin driver, compares the bus loopback at a programmable strobe phase and
// reports masked mismatches with a saturating error count.
module cycle_vector_engine #(
   parameter int w        = 1,
   parameter int PERIOD_W = 8,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [PERIOD_W-1:0] strobe,
   input  logic                vec_valid,
   output logic                vec_ready,
   input  logic [w-1:0]        vec_drive,
   input  logic [w-1:0]        vec_oe,
   input  logic [w-1:0]        vec_expect,
   input  logic [w-1:0]        vec_mask,
   output logic [w-1:0]        X_out,
   output logic [w-1:0]        X_drive,
   input  logic [w-1:0]        X_in,
   output logic                fail_valid,
   output logic [w-1:0]        fail_bits,
   output logic [CNT_W-1:0]    fail_index,
   output logic [CNT_W-1:0]    err_count,
   output logic                underrun,
   output logic                busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [PERIOD_W-1:0] phase;
   logic [PERIOD_W-1:0] last_l;     // period-1 of the running vector
   logic [PERIOD_W-1:0] strobe_l;
   logic [w-1:0]        expect_l;
   logic [w-1:0]        mask_l;
   logic [CNT_W-1:0]    index;
   logic                started;    // at least one vector accepted since reset

   logic [PERIOD_W-1:0] last_in;
   logic [PERIOD_W-1:0] strobe_in;
   logic                accept;
   logic                at_boundary;
   logic                at_strobe;
   logic [w-1:0]        mm;

   // A zero period behaves as one clk; the strobe can never lie past the last phase.
   assign last_in     = (period == '0) ? '0 : period - PERIOD_W'(1);
   assign strobe_in   = (strobe > last_in) ? last_in : strobe;

   assign at_boundary = (state_q == ACTIVE) && (phase == last_l);
   assign at_strobe   = (state_q == ACTIVE) && (phase == strobe_l);
   assign mm          = (X_in ^ expect_l) & mask_l;
   assign accept      = vec_valid & vec_ready;
   assign busy        = (state_q == ACTIVE);

   // Next-state and handshake decode; ready only opens at a vector boundary.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d   = state_q;
      vec_ready = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               vec_ready = enable;
               if (enable && vec_valid) state_d = ACTIVE;
            end
            ACTIVE: begin
               if (phase == last_l) begin
                  vec_ready = enable;
                  if (!(enable && vec_valid)) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Vector datapath: load on accept, release the bus on a stop, compare at the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         X_out      <= '0;
         X_drive    <= '0;
         expect_l   <= '0;
         mask_l     <= '0;
         last_l     <= '0;
         strobe_l   <= '0;
         phase      <= '0;
         index      <= '0;
         started    <= 1'b0;
         fail_valid <= 1'b0;
         fail_bits  <= '0;
         fail_index <= '0;
         err_count  <= '0;
         underrun   <= 1'b0;
      end else begin
         fail_valid <= 1'b0;

         // Compare uses the vector currently on the pins, even if this edge replaces it.
         if (at_strobe && (mm != '0)) begin
            fail_valid <= 1'b1;
            fail_bits  <= mm;
            fail_index <= index;
            if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
         end

         if (accept) begin
            X_out    <= vec_drive;
            X_drive  <= vec_oe;
            expect_l <= vec_expect;
            mask_l   <= vec_mask;
            last_l   <= last_in;
            strobe_l <= strobe_in;
            phase    <= '0;
            started  <= 1'b1;
            // The index names the vector: the first one after reset is 0, every later one counts up.
            if (started) index <= index + CNT_W'(1);
         end else if (at_boundary) begin
            X_drive <= '0;
            phase   <= '0;
            if (enable) underrun <= 1'b1;
         end else if (state_q == ACTIVE) begin
            phase <= phase + PERIOD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cycle_vector_engine.sv
// Self-checking bench for cycle_vector_engine: a timestamp-based tester-cycle
// model predicts pins, handshake and fail records; a monitor pops the fail
// scoreboard whenever the DUT pulses fail_valid.
module tb_cycle_vector_engine;

   localparam int W  = 4;
   localparam int PW = 8;
   localparam int CW = 2;

   typedef struct {
      logic [W-1:0] drive;
      logic [W-1:0] oe;
      logic [W-1:0] exp_v;
      logic [W-1:0] mask;
      logic [W-1:0] inj;    // bits the bus flips relative to X_out while this vector plays
   } vec_t;

   typedef struct {
      int           at;
      logic [W-1:0] bits;
      int           idx;
   } fail_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [PW-1:0] period = '0;
   logic [PW-1:0] strobe = '0;
   logic          vec_valid = 1'b0;
   logic          vec_ready;
   logic [W-1:0]  vec_drive = '0;
   logic [W-1:0]  vec_oe = '0;
   logic [W-1:0]  vec_expect = '0;
   logic [W-1:0]  vec_mask = '0;
   logic [W-1:0]  X_out;
   logic [W-1:0]  X_drive;
   logic [W-1:0]  X_in = '0;
   logic          fail_valid;
   logic [W-1:0]  fail_bits;
   logic [CW-1:0] fail_index;
   logic [CW-1:0] err_count;
   logic          underrun;
   logic          busy;

   cycle_vector_engine #(.w(W), .PERIOD_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .period(period), .strobe(strobe),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_drive(vec_drive),
      .vec_oe(vec_oe), .vec_expect(vec_expect), .vec_mask(vec_mask),
      .X_out(X_out), .X_drive(X_drive), .X_in(X_in), .fail_valid(fail_valid),
      .fail_bits(fail_bits), .fail_index(fail_index), .err_count(err_count),
      .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: state after the most recent edge.
   bit           m_active = 1'b0;
   vec_t         m_cur = '{default: '0};
   int           m_p = 1, m_s = 0, m_tacc = 0;
   int           m_idx = 0;
   bit           m_started = 1'b0;
   bit           m_under = 1'b0;
   int           m_err = 0;
   logic [W-1:0] m_xout = '0, m_xdrv = '0;
   logic [W-1:0] m_hold_bits = '0;
   int           m_hold_idx = 0;
   bit           m_accept = 1'b0;
   fail_t        fail_q[$];
   vec_t         stim_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // Called just after a falling edge with inputs set; predicts the coming rising edge.
   task automatic tick();
      int           e, k;
      bit           rdy;
      logic [W-1:0] mm;
      X_in = m_xout ^ m_cur.inj;
      #1;
      e   = cyc + 1;
      k   = e - m_tacc - 1;   // phase the running vector has reached at edge e
      rdy = !rst && enable && (!m_active || k == m_p - 1);
      check("vec_ready", vec_ready, rdy);
      m_accept = 1'b0;
      if (rst) begin
         m_active = 0; m_cur = '{default: '0}; m_idx = 0; m_started = 0;
         m_under = 0; m_err = 0; m_xout = '0; m_xdrv = '0;
         m_hold_bits = '0; m_hold_idx = 0; fail_q.delete();
      end else begin
         if (m_active && k == m_s) begin
            mm = (X_in ^ m_cur.exp_v) & m_cur.mask;
            if (mm != '0) begin
               fail_q.push_back('{at: e, bits: mm, idx: m_idx});
               m_err = (m_err == (1 << CW) - 1) ? m_err : m_err + 1;
            end
         end
         if (rdy && vec_valid) begin
            m_accept  = 1'b1;
            m_cur     = stim_q[0];
            m_idx     = m_started ? (m_idx + 1) % (1 << CW) : 0;
            m_started = 1'b1;
            m_p       = (period == '0) ? 1 : int'(period);
            m_s       = (int'(strobe) > m_p - 1) ? m_p - 1 : int'(strobe);
            m_tacc    = e;
            m_active  = 1'b1;
            m_xout    = m_cur.drive;
            m_xdrv    = m_cur.oe;
         end else if (m_active && k == m_p - 1) begin
            m_active = 1'b0;
            m_xdrv   = '0;
            if (enable) m_under = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Monitor: compares registered outputs after every rising edge and drains the fail scoreboard.
   initial begin
      bit exp_fv;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         check("X_drive", X_drive, m_xdrv);
         check("X_out", X_out, m_xout);
         check("busy", busy, m_active);
         check("underrun", underrun, m_under);
         check("err_count", err_count, m_err);
         while (fail_q.size() > 0 && fail_q[0].at < cyc) begin
            n_vec++; n_bad++;
            $display("FAIL missed_fail @cycle %0d: got none, want fail due at cycle %0d", cyc, fail_q[0].at);
            void'(fail_q.pop_front());
         end
         exp_fv = (fail_q.size() > 0) && (fail_q[0].at == cyc);
         check("fail_valid", fail_valid, exp_fv);
         if (exp_fv) begin
            m_hold_bits = fail_q[0].bits;
            m_hold_idx  = fail_q[0].idx;
            void'(fail_q.pop_front());
         end
         check("fail_bits", fail_bits, m_hold_bits);
         check("fail_index", fail_index, m_hold_idx);
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1; enable = 1'b1; vec_valid = 1'b1;
      repeat (n) tick();
      rst = 1'b0; enable = 1'b0; vec_valid = 1'b0;
   endtask

   // Plays stim_q; gap_pct drops vec_valid at random, end_en is enable once the queue drains.
   task automatic run(input int pp, input int ss, input bit end_en, input int gap_pct, input int abort_at);
      int guard = 0;
      period = PW'(pp);
      strobe = PW'(ss);
      while ((stim_q.size() > 0 || m_active) && guard < 2000) begin
         if (stim_q.size() > 0) begin
            enable     = 1'b1;
            vec_valid  = ($urandom_range(99) >= gap_pct);
            vec_drive  = stim_q[0].drive;
            vec_oe     = stim_q[0].oe;
            vec_expect = stim_q[0].exp_v;
            vec_mask   = stim_q[0].mask;
         end else begin
            enable    = end_en;
            vec_valid = 1'b0;
         end
         if (abort_at != 0 && guard == abort_at) rst = 1'b1;
         tick();
         if (m_accept) void'(stim_q.pop_front());
         if (rst) begin
            rst = 1'b0;
            stim_q.delete();
         end
         guard++;
      end
      if (guard >= 2000) begin
         n_vec++; n_bad++;
         $display("FAIL run_timeout @cycle %0d: got %0d clks, want < 2000", cyc, guard);
      end
      enable = 1'b0; vec_valid = 1'b0;
      repeat (2) tick();
   endtask

   function automatic vec_t mk(input logic [W-1:0] d, input logic [W-1:0] oe,
                               input logic [W-1:0] ex, input logic [W-1:0] mk_mask,
                               input logic [W-1:0] inj);
      vec_t v;
      v.drive = d; v.oe = oe; v.exp_v = ex; v.mask = mk_mask; v.inj = inj;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      logic [W-1:0] d;
      d = W'($urandom);
      return mk(d, W'($urandom), d, W'($urandom),
                ($urandom_range(2) == 0) ? W'($urandom) : W'(0));
   endfunction

   initial begin
      // Reset held with a vector offered and enable high.
      do_reset(3);

      // Streaming with loopback: no fails, no gaps, ready only at phase 3.
      stim_q = '{mk(4'h3, 4'hF, 4'h3, 4'hF, 4'h0), mk(4'h5, 4'hF, 4'h5, 4'hF, 4'h0),
                 mk(4'h9, 4'hF, 4'h9, 4'hF, 4'h0)};
      run(4, 2, 1'b0, 0, 0);

      // Mismatch on bit 0, then the same pattern masked off.
      stim_q = '{mk(4'hB, 4'hF, 4'hA, 4'hF, 4'h0)};
      run(4, 2, 1'b0, 0, 0);
      stim_q = '{mk(4'hB, 4'hF, 4'hA, 4'hE, 4'h0)};
      run(4, 2, 1'b0, 0, 0);

      // Underrun, restart with underrun sticky, then a clean stop after reset.
      do_reset(1);
      stim_q = '{mk(4'h1, 4'hF, 4'h1, 4'hF, 4'h0), mk(4'h2, 4'h3, 4'h2, 4'hF, 4'h0)};
      run(4, 2, 1'b1, 0, 0);
      stim_q = '{mk(4'h7, 4'hF, 4'h7, 4'hF, 4'h0)};
      run(4, 2, 1'b0, 0, 0);
      do_reset(1);
      stim_q = '{mk(4'h6, 4'hF, 4'h6, 4'hF, 4'h0), mk(4'hC, 4'hF, 4'hC, 4'hF, 4'h0)};
      run(3, 1, 1'b0, 0, 0);

      // Degenerate timing: period 0, strobe 5 -> one vector per clk, compare at phase 0.
      do_reset(1);
      for (int i = 0; i < 6; i++)
         stim_q.push_back(mk(W'(i), 4'hF, W'(i), 4'hF, (i % 2 == 1) ? W'(i) : W'(0)));
      run(0, 5, 1'b0, 0, 0);

      // Saturation: five failing vectors on a 2-bit counter.
      do_reset(1);
      for (int i = 0; i < 5; i++)
         stim_q.push_back(mk(4'h0, 4'hF, 4'hF, 4'hF, 4'h0));
      run(2, 1, 1'b0, 0, 0);

      // Abort: reset asserted in the middle of a long tester cycle.
      stim_q = '{mk(4'hD, 4'hF, 4'h0, 4'hF, 4'h0), mk(4'h4, 4'hF, 4'h4, 4'hF, 4'h0)};
      run(8, 5, 1'b0, 0, 4);

      // Randomised runs: random timing, valid gaps and stop mode.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 10; i++) stim_q.push_back(rand_vec());
         run($urandom_range(6), $urandom_range(7), 1'($urandom_range(1)), 20, 0);
      end

      repeat (3) tick();
      check("fail_q_drained", fail_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
